fp_mul_round_stage: RTL and testbench



---
 rtl/fp_mul_round_stage_if.sv | 50 +++++
 rtl/fp_mul_round_stage.sv | 164 ++++++++++++++++
 tb/tb_fp_mul_round_stage.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_round_stage_if.sv
// fp_mul_round_stage_if: upstream product handshake and downstream result
// handshake of the multiplier normalize/round stage, plus the result
// invariants that every consumer may rely on.
interface fp_mul_round_stage_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic clk,
  input logic rst_n
);
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_sign;
  logic signed [EXP_W+1:0]    in_exp;
  logic [2*(MAN_W+1)-1:0]     in_mant;
  logic [2:0]                 r_mode;
  logic                       out_valid;
  logic                       out_ready;
  logic [EXP_W+MAN_W:0]       fp_Z;
  logic                       ovrf;
  logic                       udrf;

  // Producer of products / consumer of results.
  modport master (
    output in_valid, in_sign, in_exp, in_mant, r_mode, out_ready,
    input  in_ready, out_valid, fp_Z, ovrf, udrf
  );

  // The round stage itself.
  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, r_mode, out_ready,
    output in_ready, out_valid, fp_Z, ovrf, udrf
  );

  // A zero exponent field is only ever produced as a flushed/zero result.
  a_zero_exp_udrf: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> ((fp_Z[EXP_W+MAN_W-1 -: EXP_W] != {EXP_W{1'b0}}) || udrf));

  // An all-ones exponent field is only ever produced as an overflow.
  a_inf_exp_ovrf: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> ((fp_Z[EXP_W+MAN_W-1 -: EXP_W] != {EXP_W{1'b1}}) || ovrf));

  // The two flags are mutually exclusive.
  a_flags_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(ovrf && udrf));

  // A stalled result stays put until the consumer takes it.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(fp_Z) && $stable(ovrf) && $stable(udrf)));
endinterface

// File: rtl/fp_mul_round_stage.sv
// fp_mul_round_stage: normalize/round stage of the single-precision multiplier.
// S1 normalizes the double-width significand product to MAN_W+1 bits with a
// guard and a sticky bit; S2 rounds under r_mode, classifies zero, overflow
// and underflow, and registers the packed result with its flags.
module fp_mul_round_stage #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic                  clk,
  input logic                  rst_n,
  fp_mul_round_stage_if.slave  bus
);
  localparam int EW = EXP_W + 2;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int ZW = 1 + EXP_W + MAN_W;
  localparam logic signed [EW-1:0] EXP_INF  = EW'((2 ** EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);

  // Round-up decision; unused encodings fall back to round-to-nearest-even.
  function automatic logic round_inc(
    input logic [2:0] mode,
    input logic       sign,
    input logic       lsb,
    input logic       guard,
    input logic       sticky
  );
    logic inc;
    case (mode)
      3'b001:  inc = 1'b0;                       // toward zero
      3'b010:  inc = sign && (guard || sticky);  // toward -inf
      3'b011:  inc = !sign && (guard || sticky); // toward +inf
      3'b100:  inc = guard;                      // nearest, ties away
      default: inc = guard && (sticky || lsb);   // nearest, ties even
    endcase
    return inc;
  endfunction

  logic                 s1_adv_s;
  logic                 in_fire_s;
  logic [SW-1:0]        norm_sig_s;
  logic                 norm_guard_s;
  logic                 norm_sticky_s;
  logic signed [EW-1:0] norm_exp_s;

  logic                 s1_valid_r;
  logic                 s1_sign_r;
  logic                 s1_zero_r;
  logic                 s1_guard_r;
  logic                 s1_sticky_r;
  logic [2:0]           s1_mode_r;
  logic [SW-1:0]        s1_sig_r;
  logic signed [EW-1:0] s1_exp_r;

  logic                 inc_s;
  logic                 carry_s;
  logic [MAN_W-1:0]     frac_s;
  logic signed [EW-1:0] rnd_exp_s;
  logic [ZW-1:0]        res_z_s;
  logic                 res_ov_s;
  logic                 res_ud_s;

  logic                 out_valid_r;
  logic [ZW-1:0]        fp_z_r;
  logic                 ovrf_r;
  logic                 udrf_r;

  // Pipeline flow control: S1 may move on when S2 is empty or draining.
  always_comb begin
    s1_adv_s  = !out_valid_r || bus.out_ready;
    in_fire_s = bus.in_valid && (!s1_valid_r || s1_adv_s);
  end

  assign bus.in_ready  = !s1_valid_r || s1_adv_s;
  assign bus.out_valid = out_valid_r;
  assign bus.fp_Z      = fp_z_r;
  assign bus.ovrf      = ovrf_r;
  assign bus.udrf      = udrf_r;

  // Normalize: the product of two [1,2) significands lies in [1,4), so at
  // most a one-bit right shift is needed, compensated in the exponent.
  always_comb begin
    if (bus.in_mant[PW-1]) begin
      norm_sig_s    = bus.in_mant[PW-1 -: SW];
      norm_guard_s  = bus.in_mant[MAN_W];
      norm_sticky_s = |bus.in_mant[MAN_W-1:0];
      norm_exp_s    = bus.in_exp + EXP_ONE;
    end else begin
      norm_sig_s    = bus.in_mant[PW-2 -: SW];
      norm_guard_s  = bus.in_mant[MAN_W-1];
      norm_sticky_s = |bus.in_mant[MAN_W-2:0];
      norm_exp_s    = bus.in_exp;
    end
  end

  // S1 register: normalized significand, rounding bits, mode and sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_sign_r   <= 1'b0;
      s1_zero_r   <= 1'b0;
      s1_guard_r  <= 1'b0;
      s1_sticky_r <= 1'b0;
      s1_mode_r   <= 3'b000;
      s1_sig_r    <= {SW{1'b0}};
      s1_exp_r    <= EXP_ZERO;
    end else if (in_fire_s) begin
      s1_valid_r  <= 1'b1;
      s1_sign_r   <= bus.in_sign;
      s1_zero_r   <= (bus.in_mant == {PW{1'b0}});
      s1_guard_r  <= norm_guard_s;
      s1_sticky_r <= norm_sticky_s;
      s1_mode_r   <= bus.r_mode;
      s1_sig_r    <= norm_sig_s;
      s1_exp_r    <= norm_exp_s;
    end else if (s1_adv_s) begin
      s1_valid_r  <= 1'b0;
    end
  end

  // Round and classify. A carry out of sig+inc only happens when the whole
  // significand is ones; the fraction then wraps to zero on its own, so only
  // the exponent needs the carry.
  always_comb begin
    inc_s     = round_inc(s1_mode_r, s1_sign_r, s1_sig_r[0], s1_guard_r, s1_sticky_r);
    carry_s   = inc_s && (&s1_sig_r);
    frac_s    = s1_sig_r[MAN_W-1:0] + {{(MAN_W-1){1'b0}}, inc_s};
    rnd_exp_s = s1_exp_r + {{(EW-1){1'b0}}, carry_s};
    res_z_s   = {s1_sign_r, rnd_exp_s[EXP_W-1:0], frac_s};
    res_ov_s  = 1'b0;
    res_ud_s  = 1'b0;
    if (s1_zero_r) begin
      res_z_s  = {s1_sign_r, {(ZW-1){1'b0}}};
      res_ud_s = 1'b1;
    end else if (rnd_exp_s >= EXP_INF) begin
      res_z_s  = {s1_sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_ov_s = 1'b1;
    end else if (rnd_exp_s <= EXP_ZERO) begin
      res_z_s  = {s1_sign_r, {(ZW-1){1'b0}}};
      res_ud_s = 1'b1;
    end else begin
      res_ov_s = 1'b0;
      res_ud_s = 1'b0;
    end
  end

  // S2 register: the visible result; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      fp_z_r      <= {ZW{1'b0}};
      ovrf_r      <= 1'b0;
      udrf_r      <= 1'b0;
    end else if (s1_adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        fp_z_r <= res_z_s;
        ovrf_r <= res_ov_s;
        udrf_r <= res_ud_s;
      end
    end
  end
endmodule

// File: tb/tb_fp_mul_round_stage.sv
// tb_fp_mul_round_stage: directed vectors for the multiplier round stage,
// followed by a backpressure sequence and a reset-while-busy sequence.
module tb_fp_mul_round_stage;
  typedef struct {
    logic              sign;
    logic signed [9:0] exp;
    logic [47:0]       mant;
    logic [2:0]        mode;
    logic [31:0]       z;
    logic              ov;
    logic              ud;
  } vec_t;

  localparam int NV = 25;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  vec_t vecs [NV];
  int   bp_idx [4];

  fp_mul_round_stage_if #(.EXP_W(8), .MAN_W(23)) bus (.clk(clk), .rst_n(rst_n));

  fp_mul_round_stage #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, need %h", name, act, req);
    end
  endtask

  task automatic drive(input int i);
    bus.in_sign = vecs[i].sign;
    bus.in_exp  = vecs[i].exp;
    bus.in_mant = vecs[i].mant;
    bus.r_mode  = vecs[i].mode;
  endtask

  task automatic check_out(input string tag, input int i);
    check({tag, " fp_Z"}, bus.fp_Z, vecs[i].z);
    check({tag, " ovrf"}, 32'(bus.ovrf), 32'(vecs[i].ov));
    check({tag, " udrf"}, 32'(bus.udrf), 32'(vecs[i].ud));
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  sent;
    int  got;
    logic acc;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_exp    = 10'sd0;
    bus.in_mant   = 48'h0;
    bus.r_mode    = 3'b000;

    //           sign  exp       mant                 mode    fp_Z           ov    ud
    vecs[0]  = '{1'b0, 10'sd127, 48'h9000_0000_0000, 3'b000, 32'h4010_0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 10'sd127, 48'h4000_0040_0000, 3'b000, 32'h3F80_0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 10'sd127, 48'h4000_0040_0000, 3'b100, 32'h3F80_0001, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 10'sd127, 48'h4000_0040_0000, 3'b011, 32'h3F80_0001, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 10'sd127, 48'h4000_0040_0000, 3'b010, 32'h3F80_0000, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 10'sd127, 48'h4000_0040_0000, 3'b001, 32'h3F80_0000, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 10'sd127, 48'h4000_0040_0000, 3'b010, 32'hBF80_0001, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 10'sd127, 48'h4000_0040_0000, 3'b011, 32'hBF80_0000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 10'sd127, 48'h7FFF_FFC0_0000, 3'b000, 32'h4000_0000, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 10'sd127, 48'h7FFF_FFC0_0000, 3'b001, 32'h3FFF_FFFF, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 10'sd254, 48'h8000_0000_0000, 3'b000, 32'h7F80_0000, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 10'sd254, 48'h8000_0000_0000, 3'b000, 32'hFF80_0000, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 10'sd0,   48'h4000_0000_0000, 3'b000, 32'h0000_0000, 1'b0, 1'b1};
    vecs[13] = '{1'b0, -10'sd5,  48'h4000_0000_0000, 3'b000, 32'h0000_0000, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 10'sd127, 48'h0000_0000_0000, 3'b000, 32'h8000_0000, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 10'sd253, 48'hFFFF_FF80_0000, 3'b000, 32'h7F80_0000, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 10'sd1,   48'h4000_0000_0000, 3'b000, 32'h0080_0000, 1'b0, 1'b0};
    vecs[17] = '{1'b0, -10'sd1,  48'h8000_0000_0000, 3'b000, 32'h0000_0000, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 10'sd127, 48'h4000_0060_0000, 3'b000, 32'h3F80_0001, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 10'sd127, 48'h4000_00C0_0000, 3'b111, 32'h3F80_0002, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 10'sd127, 48'h4000_00C0_0000, 3'b101, 32'h3F80_0002, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 10'sd127, 48'h4000_0020_0000, 3'b100, 32'h3F80_0000, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 10'sd127, 48'h4000_0020_0000, 3'b011, 32'h3F80_0001, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 10'sd254, 48'h4000_0000_0000, 3'b000, 32'h7F00_0000, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 10'sd300, 48'h0000_0000_0000, 3'b000, 32'h0000_0000, 1'b0, 1'b1};

    bp_idx[0] = 0;
    bp_idx[1] = 8;
    bp_idx[2] = 10;
    bp_idx[3] = 14;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst fp_Z", bus.fp_Z, 32'h0);
    check("rst ovrf", 32'(bus.ovrf), 32'd0);
    check("rst udrf", 32'(bus.udrf), 32'd0);
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    cyc();

    // Table: one transfer each, fixed two-cycle latency.
    bus.out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(i);
      bus.in_valid = 1'b1;
      #1;
      check($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'd1);
      cyc();
      bus.in_valid = 1'b0;
      check($sformatf("v%0d early out_valid", i), 32'(bus.out_valid), 32'd0);
      cyc();
      check($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'd1);
      check_out($sformatf("v%0d", i), i);
    end
    cyc();

    // Backpressure: four back-to-back inputs, consumer stalled for 4 cycles.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (sent < 4) begin
        drive(bp_idx[sent]);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = (c >= 4);
      #1;
      if (c == 2 || c == 3) begin
        check($sformatf("bp c%0d in_ready", c), 32'(bus.in_ready), 32'd0);
        check($sformatf("bp c%0d out_valid", c), 32'(bus.out_valid), 32'd1);
        check($sformatf("bp c%0d held fp_Z", c), bus.fp_Z, vecs[bp_idx[0]].z);
      end
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        check_out($sformatf("bp out%0d", got), bp_idx[got]);
        got++;
      end
      @(posedge clk);
      #1;
      if (acc) sent++;
    end
    bus.in_valid = 1'b0;
    check("bp sent count", 32'(sent), 32'd4);
    check("bp result count", 32'(got), 32'd4);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp drained %0d", k), 32'(bus.out_valid), 32'd0);
      cyc();
    end

    // Reset with two entries in flight: nothing may come out afterwards.
    bus.out_ready = 1'b0;
    drive(16);
    bus.in_valid = 1'b1;
    cyc();
    drive(18);
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    check("busy out_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst in_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    cyc();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      check($sformatf("postrst out_valid %0d", k), 32'(bus.out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
